// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU control path:
// opcodes, FSM state encoding and instruction field positions.
package cpu_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   localparam int OP_HI = 8;
   localparam int OP_LO = 6;
   localparam int X_HI  = 5;
   localparam int X_LO  = 3;
   localparam int Y_HI  = 2;
   localparam int Y_LO  = 0;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

endpackage

// File: rtl/dec_onehot.sv
// 3-bit index to N-wide one-hot decoder with enable.
// Indices at or beyond N decode to all zeros.
module dec_onehot #(
   parameter int N = 8
) (
   input  logic         en,
   input  logic [2:0]   idx,
   output logic [N-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (en && (int'(idx) == i))
            onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM: decodes ir and sequences register
// enables and shared-bus selects across T0..T3.
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int IR_WIDTH = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [IR_WIDTH-1:0] ir,
   output logic                IRin,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                DINout,
   output logic                Gout,
   output logic                Ain,
   output logic                Gin,
   output logic                AddSub,
   output logic                done
);

   state_t     state_q;
   state_t     state_d;
   logic [2:0] op;
   logic [2:0] fx;
   logic [2:0] fy;

   logic       irin_c;
   logic       rin_en;
   logic       rout_en;
   logic       rout_y;
   logic       din_c;
   logic       gout_c;
   logic       ain_c;
   logic       gin_c;
   logic       addsub_c;
   logic       done_c;
   logic [2:0] rout_idx;

   assign op = ir[OP_HI:OP_LO];
   assign fx = ir[X_HI:X_LO];
   assign fy = ir[Y_HI:Y_LO];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= T0;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      irin_c   = 1'b0;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      rout_y   = 1'b0;
      din_c    = 1'b0;
      gout_c   = 1'b0;
      ain_c    = 1'b0;
      gin_c    = 1'b0;
      addsub_c = 1'b0;
      done_c   = 1'b0;
      unique case (state_q)
         T0: begin
            irin_c = run;
            if (run)
               state_d = T1;
         end
         T1: begin
            state_d = T0;
            unique case (1'b1)
               (op == OP_MV): begin
                  rout_en = 1'b1;
                  rout_y  = 1'b1;
                  rin_en  = 1'b1;
                  done_c  = 1'b1;
               end
               (op == OP_MVI): begin
                  din_c  = 1'b1;
                  rin_en = 1'b1;
                  done_c = 1'b1;
               end
               (op == OP_ADD),
               (op == OP_SUB): begin
                  rout_en = 1'b1;
                  ain_c   = 1'b1;
                  state_d = T2;
               end
               default: done_c = 1'b1;
            endcase
         end
         T2: begin
            rout_en  = 1'b1;
            rout_y   = 1'b1;
            gin_c    = 1'b1;
            addsub_c = (op == OP_SUB);
            state_d  = T3;
         end
         T3: begin
            gout_c  = 1'b1;
            rin_en  = 1'b1;
            done_c  = 1'b1;
            state_d = T0;
         end
         default: state_d = T0;
      endcase
   end

   assign rout_idx = rout_y ? fy : fx;

   // Decoder enables carry the reset gate so Rin/Rout clear asynchronously
   dec_onehot #(.N(NUM_REGS)) u_dec_rin (
      .en     (rin_en & reset),
      .idx    (fx),
      .onehot (Rin)
   );

   dec_onehot #(.N(NUM_REGS)) u_dec_rout (
      .en     (rout_en & reset),
      .idx    (rout_idx),
      .onehot (Rout)
   );

   assign IRin   = irin_c   & reset;
   assign DINout = din_c    & reset;
   assign Gout   = gout_c   & reset;
   assign Ain    = ain_c    & reset;
   assign Gin    = gin_c    & reset;
   assign AddSub = addsub_c & reset;
   assign done   = done_c   & reset;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed table,
// reset corner case and a random stream against a queue model.
module tb_cpu_ctrl_fsm;

   typedef struct packed {
      logic       irin;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       din;
      logic       gout;
      logic       ain;
      logic       gin;
      logic       addsub;
      logic       done;
   } out_t;

   typedef struct {
      logic       run;
      logic [8:0] ir;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [8:0] ir = '0;
   logic       IRin;
   logic [7:0] Rin;
   logic [7:0] Rout;
   logic       DINout;
   logic       Gout;
   logic       Ain;
   logic       Gin;
   logic       AddSub;
   logic       done;
   out_t       act;

   int checks = 0;
   int failures = 0;

   out_t q[$];
   vec_t tbl[15];

   cpu_ctrl_fsm #(.NUM_REGS(8), .IR_WIDTH(9)) dut (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .ir     (ir),
      .IRin   (IRin),
      .Rin    (Rin),
      .Rout   (Rout),
      .DINout (DINout),
      .Gout   (Gout),
      .Ain    (Ain),
      .Gin    (Gin),
      .AddSub (AddSub),
      .done   (done)
   );

   always #5 clk = ~clk;

   assign act = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, done};

   function automatic out_t o(logic irin, logic [7:0] rin,
                              logic [7:0] rout, logic din,
                              logic gout, logic ain, logic gin,
                              logic as, logic dn);
      out_t r;
      r.irin = irin;  r.rin = rin;   r.rout = rout;
      r.din = din;    r.gout = gout; r.ain = ain;
      r.gin = gin;    r.addsub = as; r.done = dn;
      return r;
   endfunction

   task automatic chk(input string name, input out_t a, input out_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic cyc(input logic r, input logic [8:0] i);
      @(posedge clk);
      #1;
      run = r;
      ir = i;
      @(negedge clk);
   endtask

   // Expected per-cycle outputs of one instruction, from T1 onward
   task automatic expand(input logic [8:0] i);
      logic [2:0] opc;
      logic [7:0] rx;
      logic [7:0] ry;
      opc = i[8:6];
      rx = 8'(1) << i[5:3];
      ry = 8'(1) << i[2:0];
      case (opc)
         3'd0: q.push_back(o(0, rx, ry, 0, 0, 0, 0, 0, 1));
         3'd1: q.push_back(o(0, rx, 0, 1, 0, 0, 0, 0, 1));
         3'd2, 3'd3: begin
            q.push_back(o(0, 0, rx, 0, 0, 1, 0, 0, 0));
            q.push_back(o(0, 0, ry, 0, 0, 0, 1, opc == 3'd3, 0));
            q.push_back(o(0, rx, 0, 0, 1, 0, 0, 0, 1));
         end
         default: q.push_back(o(0, 0, 0, 0, 0, 0, 0, 0, 1));
      endcase
   endtask

   initial begin
      out_t       z;
      out_t       e;
      logic       cr;
      logic [8:0] ci;
      int         n_instr;
      int         cycles;
      int         dcnt;
      int         nbus;

      z = o(0, 0, 0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = '{1, 9'b000_011_101, o(1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{0, 9'b000_011_101, o(0, 8'h08, 8'h20, 0, 0, 0, 0, 0, 1)};
      tbl[2]  = '{0, 9'b000_011_101, o(0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[3]  = '{1, 9'b001_111_000, o(1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[4]  = '{1, 9'b001_111_000, o(0, 8'h80, 0, 1, 0, 0, 0, 0, 1)};
      tbl[5]  = '{1, 9'b011_010_001, o(1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[6]  = '{1, 9'b011_010_001, o(0, 0, 8'h04, 0, 0, 1, 0, 0, 0)};
      tbl[7]  = '{1, 9'b011_010_001, o(0, 0, 8'h02, 0, 0, 0, 1, 1, 0)};
      tbl[8]  = '{1, 9'b011_010_001, o(0, 8'h04, 0, 0, 1, 0, 0, 0, 1)};
      tbl[9]  = '{0, 9'b101_110_011, o(0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[10] = '{1, 9'b101_110_011, o(1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[11] = '{0, 9'b101_110_011, o(0, 0, 0, 0, 0, 0, 0, 0, 1)};
      tbl[12] = '{0, 9'b101_110_011, o(0, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[13] = '{1, 9'b000_010_010, o(1, 0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[14] = '{0, 9'b000_010_010, o(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 1)};

      // reset held low with run=1
      reset = 1'b0;
      run = 1'b1;
      @(negedge clk);
      chk("reset_c0", act, z);
      @(negedge clk);
      chk("reset_c1", act, z);

      @(posedge clk);
      #1;
      reset = 1'b1;
      run = tbl[0].run;
      ir = tbl[0].ir;
      @(negedge clk);
      chk("tbl0", act, tbl[0].exp);
      for (int k = 1; k < 15; k++) begin
         cyc(tbl[k].run, tbl[k].ir);
         chk($sformatf("tbl%0d", k), act, tbl[k].exp);
      end

      // add R1,R1 abandoned by reset in T2
      cyc(1, 9'b010_001_001);
      chk("add_t0", act, o(1, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(0, 9'b010_001_001);
      chk("add_t1", act, o(0, 0, 8'h02, 0, 0, 1, 0, 0, 0));
      cyc(0, 9'b010_001_001);
      chk("add_t2", act, o(0, 0, 8'h02, 0, 0, 0, 1, 0, 0));
      #1;
      reset = 1'b0;
      #1;
      chk("rst_async", act, z);
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold", act, z);
      reset = 1'b1;
      #1;
      chk("rst_release", act, z);
      cyc(0, 9'b010_001_001);
      chk("no_done", act, z);
      cyc(1, 9'b010_001_001);
      chk("t0_after_rst", act, o(1, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(0, 9'b010_001_001);
      chk("add2_t1", act, o(0, 0, 8'h02, 0, 0, 1, 0, 0, 0));
      cyc(0, 9'b010_001_001);
      chk("add2_t2", act, o(0, 0, 8'h02, 0, 0, 0, 1, 0, 0));
      cyc(0, 9'b010_001_001);
      chk("add2_t3", act, o(0, 8'h02, 0, 0, 1, 0, 0, 0, 1));

      // random stream against the queue model
      n_instr = 0;
      cycles = 0;
      dcnt = 0;
      ci = '0;
      q.delete();
      while (n_instr < 1000 && cycles < 20000) begin
         if (q.size() == 0)
            ci = 9'($urandom);
         cr = ($urandom_range(0, 3) != 0);
         cyc(cr, ci);
         e = (q.size() != 0) ? q[0] : o(cr, 0, 0, 0, 0, 0, 0, 0, 0);
         chk("rand", act, e);
         nbus = $countones(Rout) + int'(DINout) + int'(Gout);
         checks++;
         if (nbus > 1 || !$onehot0(Rin)) begin
            failures++;
            $display("FAIL bus_excl: drivers=%0d rin=%h required <=1", nbus, Rin);
         end
         if (done)
            dcnt++;
         if (q.size() != 0) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
               checks++;
               if (dcnt != 1) begin
                  failures++;
                  $display("FAIL done_once: got %0d required 1", dcnt);
               end
               dcnt = 0;
               n_instr++;
            end
         end else if (cr) begin
            expand(ci);
         end
         cycles++;
      end
      checks++;
      if (n_instr < 1000) begin
         failures++;
         $display("FAIL rand_budget: got %0d instrs required 1000", n_instr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit for the simple CPU datapath. It decodes the instruction held in the instruction register and sequences the per-cycle enables for the general-purpose registers, the A and G registers, the IR, and the shared-bus tri-state/mux selects. It sits directly upstream of the 16-bit register bank: every Rin/Ain/Gin/IRin output drives the en input of one register instance.

Parameters:
NUM_REGS, 8, number of general-purpose registers (R0..R7); sets the Rin/Rout width
IR_WIDTH, 9, instruction width: ir[8:6]=opcode, ir[5:3]=X (destination), ir[2:0]=Y (source)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  start request; sampled only in state T0
ir  input  IR_WIDTH  instruction from IR register output (stable T1..T3)
IRin  output  1  IR register enable
Rin  output  NUM_REGS  one-hot GPR load enables
Rout  output  NUM_REGS  one-hot GPR bus-drive selects
DINout  output  1  drive external data input onto bus
Gout  output  1  drive G register onto bus
Ain  output  1  A register enable
Gin  output  1  G register enable
AddSub  output  1  ALU op: 0=add, 1=sub
done  output  1  single-cycle pulse in last cycle of instruction

Behaviour:
- One clock; reset is asynchronous and active-low (port reset; clock port clk).
- States: T0 (fetch/idle), T1, T2, T3; 2-bit registered state. Reset forces T0 immediately.
- All outputs: combinational decode of registered state and ir, forced to 0 while reset=0. Default 0 everywhere.
- T0: IRin=run. Next state T1 if run=1, else T0. run is ignored in T1..T3.
- Opcode 000 mv Rx,Ry: T1: Rout[Y]=1, Rin[X]=1, done=1 -> T0. One cycle after IR load.
- Opcode 001 mvi Rx,#D: T1: DINout=1, Rin[X]=1, done=1 -> T0.
- Opcode 010 add Rx,Ry: T1: Rout[X], Ain -> T2: Rout[Y], Gin, AddSub=0 -> T3: Gout, Rin[X], done -> T0.
- Opcode 011 sub Rx,Ry: as add, with AddSub=1 in T2. AddSub=0 in all other cycles.
- Opcodes 100..111 (reserved): T1: done=1, no enables, no bus driver -> T0. Treated as a NOP.
- mv with X==Y: Rin[X] and Rout[X] are both asserted in the same cycle; the register reloads its own value. Legal.
- Bus exclusivity invariant: in every cycle, at most one of {Rout[*], DINout, Gout} is asserted. Rin, Ain and Gin are each at most one-hot.
- done is high for exactly one cycle per instruction and never in T0.
- Back-to-back: if run stays 1, the T0 cycle after done loads the next IR. Minimum issue interval: 2 cycles (mv/mvi), 4 cycles (add/sub).
- Reset mid-instruction (any state): outputs go to 0 asynchronously, state is T0 on the next edge after release, and the partial instruction is abandoned. Register contents are not this block's responsibility.
- X/Y index beyond NUM_REGS-1 (only possible if NUM_REGS<8): no Rin/Rout bit asserted.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB), state encoding (T0..T3), field slice positions for opcode/X/Y.
- Sub-module dec_onehot (3-to-NUM_REGS one-hot decoder with enable), instantiated twice: once for Rin (X), once for Rout (X/Y mux).
- The FSM next-state logic and output decode remain in cpu_ctrl_fsm.

Test Plan:
- Reset=0 for 2 cycles with run=1 -> all outputs 0. Release -> T0, IRin=1 in the same cycle as run=1.
- ir=9'b000_011_101 (mv R3,R5) -> T1: Rout=8'h20, Rin=8'h08, done=1; the next cycle is T0 with all enables 0.
- ir=9'b001_111_000 (mvi R7) -> T1: DINout=1, Rin=8'h80, done=1. run held 1 -> IRin=1 in the following cycle (back-to-back).
- ir=9'b011_010_001 (sub R2,R1) -> T1: Rout=8'h04, Ain=1; T2: Rout=8'h02, Gin=1, AddSub=1; T3: Gout=1, Rin=8'h04, done=1.
- ir=9'b010_001_001 (add R1,R1) with reset pulsed low in T2 -> outputs 0 asynchronously; after release the FSM is in T0, and done never pulsed for that instruction.
- Random ir/run stream of 1000 instructions including opcodes 100..111 -> bus exclusivity and done-once-per-instruction invariants hold. Reserved opcodes produce done in T1 with Rin=0.
